// File: rtl/cu_pkg.sv
// Shared control-unit definitions: control-word bit indices (also used by the
// ALU), opcode values and the sequencer state encoding.
package cu_pkg;

  localparam int CS_W = 27;

  // Control-word bit indices
  localparam int ADD_B     = 0;
  localparam int COMP_B    = 1;
  localparam int SUB_B     = 2;
  localparam int XORR_B    = 3;
  localparam int ANDD_B    = 4;
  localparam int ORR_B     = 5;
  localparam int ACC_IN_B  = 6;
  localparam int ACC_OUT_B = 7;
  localparam int PC_OUT_B  = 8;
  localparam int PC_INC_B  = 9;
  localparam int MAR_IN_B  = 10;
  localparam int MEM_RD_B  = 11;
  localparam int MDR_OUT_B = 12;
  localparam int IR_IN_B   = 13;
  localparam int FLAG_IN_B = 14;
  localparam int Z_OUT_B   = 25;

  // Opcodes (ir[7:4])
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_CMP = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ST_SPARE is never entered; it falls back to F0.
  typedef enum logic [2:0] {
    ST_F0, ST_F1, ST_DC, ST_OA, ST_OR, ST_WB, ST_HALT, ST_SPARE
  } state_t;

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'h8) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/cs_decode.sv
// Combinational control-word decoder.
// Ports: state (sequencer state), op (ir[7:4]), mem_rdy (read data valid),
//        cs (control word), illegal (undefined opcode seen in decode).
// mem_rdy only reaches the word in F1 and OR, where it gates the strobes
// that consume the read data.
module cs_decode
  import cu_pkg::*;
#(
  parameter int SZ = CS_W
) (
  input  logic [2:0]    state,
  input  logic [3:0]    op,
  input  logic          mem_rdy,
  output logic [SZ-1:0] cs,
  output logic          illegal
);

  state_t st;
  assign st = state_t'(state);

  always_comb begin
    cs      = '0;
    illegal = 1'b0;
    case (st)
      ST_F0, ST_OA: begin
        cs[PC_OUT_B] = 1'b1;
        cs[MAR_IN_B] = 1'b1;
      end
      ST_F1: begin
        cs[MEM_RD_B] = 1'b1;
        if (mem_rdy) begin
          cs[IR_IN_B]  = 1'b1;
          cs[PC_INC_B] = 1'b1;
        end
      end
      ST_DC: illegal = is_illegal(op);
      ST_OR: begin
        cs[MEM_RD_B] = 1'b1;
        if (mem_rdy) begin
          cs[MDR_OUT_B] = 1'b1;
          cs[PC_INC_B]  = 1'b1;
          case (op)
            OP_LDI: cs[ACC_IN_B] = 1'b1;
            OP_ADD: cs[ADD_B]    = 1'b1;
            OP_SUB: cs[SUB_B]    = 1'b1;
            OP_CMP: cs[COMP_B]   = 1'b1;
            OP_XOR: cs[XORR_B]   = 1'b1;
            OP_AND: cs[ANDD_B]   = 1'b1;
            OP_OR:  cs[ORR_B]    = 1'b1;
            default: ;
          endcase
        end
      end
      ST_WB: begin
        cs[Z_OUT_B] = 1'b1;
        // CMP only updates flags; the other ALU ops write the accumulator.
        if (op == OP_CMP)  cs[FLAG_IN_B] = 1'b1;
        else if (is_alu(op)) cs[ACC_IN_B] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer.
// Ports: CLK (rising edge), RST_N (async active-low), ibus (opcode/operand
//        byte), mem_rdy (read data valid), CS_bus (control word), halted
//        (high in HALT), illegal (one-cycle pulse on undefined opcode).
// Holds the state register, ir and halted; the control word comes from
// cs_decode and is forced to zero while reset is asserted.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int SZ = CS_W
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [7:0]    ibus,
  input  logic          mem_rdy,
  output logic [SZ-1:0] CS_bus,
  output logic          halted,
  output logic          illegal
);

  state_t        state;
  logic [7:0]    ir;
  logic [3:0]    op;
  logic [SZ-1:0] cs_raw;
  logic          ill_raw;
  logic          ir_lo_unused;

  assign op           = ir[7:4];
  assign ir_lo_unused = ^ir[3:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_F0;
      ir     <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_F0: state <= ST_F1;
        ST_F1: if (mem_rdy) begin
          ir    <= ibus;
          state <= ST_DC;
        end
        ST_DC: begin
          if (is_alu(op) || op == OP_LDI) state <= ST_OA;
          else if (op == OP_HLT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else state <= ST_F0;
        end
        ST_OA: state <= ST_OR;
        ST_OR: if (mem_rdy) state <= (op == OP_LDI) ? ST_F0 : ST_WB;
        ST_WB: state <= ST_F0;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_F0;
      endcase
    end
  end

  cs_decode #(.SZ(SZ)) u_dec (
    .state   (state),
    .op      (op),
    .mem_rdy (mem_rdy),
    .cs      (cs_raw),
    .illegal (ill_raw)
  );

  // Reset parks the FSM in F0, whose word is non-zero; mask it while held.
  assign CS_bus  = RST_N ? cs_raw : '0;
  assign illegal = RST_N & ill_raw;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each instruction is expanded into
// its expected per-cycle control trace plus the memory-side drive values;
// a monitor pops one expectation per cycle and compares.
module tb_control_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  ibus = 8'h00;
  logic        mem_rdy = 1'b0;
  logic [26:0] CS_bus;
  logic        halted, illegal;

  control_sequencer #(.SZ(27)) dut (
    .CLK(CLK), .RST_N(RST_N), .ibus(ibus), .mem_rdy(mem_rdy),
    .CS_bus(CS_bus), .halted(halted), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  localparam logic [26:0] M_ADD = 27'd1 << 0,  M_COMP = 27'd1 << 1,
                          M_SUB = 27'd1 << 2,  M_XORR = 27'd1 << 3,
                          M_ANDD = 27'd1 << 4, M_ORR = 27'd1 << 5,
                          M_ACC_IN = 27'd1 << 6, M_PC_OUT = 27'd1 << 8,
                          M_PC_INC = 27'd1 << 9, M_MAR_IN = 27'd1 << 10,
                          M_MEM_RD = 27'd1 << 11, M_MDR_OUT = 27'd1 << 12,
                          M_IR_IN = 27'd1 << 13, M_FLAG_IN = 27'd1 << 14,
                          M_Z_OUT = 27'd1 << 25;

  typedef struct packed {
    logic [26:0] cs;
    logic        halted;
    logic        illegal;
  } exp_t;

  exp_t       exp_q[$];
  logic       drv_rdy[$];
  logic [7:0] drv_bus[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         mon_on  = 0;

  function automatic logic [26:0] alu_mask(input logic [3:0] op);
    case (op)
      4'h1: return M_ADD;
      4'h2: return M_SUB;
      4'h3: return M_COMP;
      4'h4: return M_XORR;
      4'h5: return M_ANDD;
      4'h6: return M_ORR;
      default: return '0;
    endcase
  endfunction

  task automatic push(input logic [26:0] cs, input logic h, input logic il,
                      input logic rdy, input logic [7:0] bus);
    exp_t e;
    e.cs = cs; e.halted = h; e.illegal = il;
    exp_q.push_back(e);
    drv_rdy.push_back(rdy);
    drv_bus.push_back(bus);
  endtask

  // Cycle where the sequencer must ignore the memory side.
  task automatic push_dc(input logic [26:0] cs, input logic h, input logic il);
    push(cs, h, il, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  // Expected trace of one instruction; w1/w2 are not-ready cycles on the
  // opcode fetch and operand read.
  task automatic gen_instr(input logic [7:0] opb, input logic [7:0] imm,
                           input int w1, input int w2);
    logic [3:0] op;
    op = opb[7:4];
    push_dc(M_PC_OUT | M_MAR_IN, 1'b0, 1'b0);
    repeat (w1) push(M_MEM_RD, 1'b0, 1'b0, 1'b0, 8'($urandom));
    push(M_MEM_RD | M_IR_IN | M_PC_INC, 1'b0, 1'b0, 1'b1, opb);
    push_dc('0, 1'b0, (op >= 4'h8 && op <= 4'hE));
    if (op >= 4'h1 && op <= 4'h7) begin
      push_dc(M_PC_OUT | M_MAR_IN, 1'b0, 1'b0);
      repeat (w2) push(M_MEM_RD, 1'b0, 1'b0, 1'b0, 8'($urandom));
      push(M_MEM_RD | M_MDR_OUT | M_PC_INC |
           ((op == 4'h7) ? M_ACC_IN : alu_mask(op)), 1'b0, 1'b0, 1'b1, imm);
      if (op != 4'h7)
        push_dc(M_Z_OUT | ((op == 4'h3) ? M_FLAG_IN : M_ACC_IN), 1'b0, 1'b0);
    end
  endtask

  task automatic gen_halt(input int n);
    repeat (n) push_dc('0, 1'b1, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; applies one drive entry per cycle.
  task automatic run();
    mon_on = 1;
    while (drv_rdy.size() > 0) begin
      mem_rdy = drv_rdy.pop_front();
      ibus    = drv_bus.pop_front();
      @(posedge CLK);
      #1;
    end
    mon_on = 0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge CLK);
      if (mon_on && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({CS_bus, halted, illegal} !== e) begin
          n_fail++;
          $display("FAIL trace[%0d]: got cs=%h halted=%b illegal=%b expected cs=%h halted=%b illegal=%b",
                   cyc, CS_bus, halted, illegal, e.cs, e.halted, e.illegal);
        end
        cyc++;
      end
    end
  end

  initial begin
    logic [3:0] op;
    // Reset state with live-looking memory inputs.
    RST_N = 1'b0; mem_rdy = 1'b1; ibus = 8'hFF;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_cs", 32'(CS_bus), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_ir", 32'(dut.ir), 32'd0);

    // Directed programme followed by random instructions, ending in HLT.
    gen_instr(8'h10, 8'h05, 0, 0);
    gen_instr(8'h30, 8'h77, 0, 0);
    gen_instr(8'h72, 8'h3C, 3, 1);
    gen_instr(8'h9A, 8'h00, 0, 0);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 14));
      gen_instr({op, 4'($urandom)}, 8'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    gen_instr(8'hF0, 8'h00, 0, 0);
    gen_halt(8);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    run();

    // Reset out of HALT.
    RST_N = 1'b0;
    #1 check("halt_rst_halted", 32'(halted), 32'd0);
    @(posedge CLK);
    #1;
    // ADD up to its operand read, then reset mid-read.
    push_dc(M_PC_OUT | M_MAR_IN, 1'b0, 1'b0);
    push(M_MEM_RD | M_IR_IN | M_PC_INC, 1'b0, 1'b0, 1'b1, 8'h1F);
    push_dc('0, 1'b0, 1'b0);
    push_dc(M_PC_OUT | M_MAR_IN, 1'b0, 1'b0);
    RST_N = 1'b1;
    run();
    mem_rdy = 1'b0;
    #1 check("or_hold_cs", 32'(CS_bus), 32'(M_MEM_RD));
    check("or_ir_loaded", 32'(dut.ir), 32'h1F);
    #1 RST_N = 1'b0;
    #1 check("mid_rst_cs", 32'(CS_bus), 32'd0);
    check("mid_rst_ir", 32'(dut.ir), 32'd0);
    check("mid_rst_illegal", 32'(illegal), 32'd0);
    @(posedge CLK);
    #1;
    gen_instr(8'h50, 8'hA5, 0, 2);
    gen_instr(8'h00, 8'h00, 1, 0);
    gen_instr(8'hE3, 8'h00, 0, 0);
    gen_instr(8'hF7, 8'h00, 2, 0);
    gen_halt(4);
    RST_N = 1'b1;
    run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired fetch/decode/execute sequencer. Generates the SZ-bit one-hot-per-function control word CS_bus consumed by the ALU, accumulator, PC, MAR/MDR and memory.
- Sits on the producer side of the CS_bus interface: the ALU reads op-select bits 0-5 and Z-out bit 25; this block drives them.
- Loads the instruction register from ibus and stalls on a memory-ready handshake.

Parameters:
- SZ, 27, CS_bus width; fixed bit map below, bits not listed are driven 0.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ibus  in  8  internal data bus; holds the opcode byte during instruction fetch.
- mem_rdy  in  1  memory read data valid on ibus this cycle.
- CS_bus  out  SZ  control word.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- CS_bus bit map:
  - 0 add, 1 comp, 2 sub, 3 xorr, 4 andd, 5 orr (ALU selects)
  - 6 acc_in, 7 acc_out, 8 pc_out, 9 pc_inc, 10 mar_in, 11 mem_rd, 12 mdr_out, 13 ir_in, 14 flag_in
  - 25 z_out
- Opcode = ir[7:4]:
  - 0 NOP, 1 ADD, 2 SUB, 3 CMP, 4 XOR, 5 AND, 6 OR, 7 LDI, F HLT
  - 8-E illegal, treated as NOP.
- ALU-class opcodes (1-6) take an immediate operand: the byte following the opcode in memory.
- CS_bus is Moore: a function of the state register and ir only. No path from mem_rdy except where noted for F1 and OR.
- At most one ALU-select bit (0-5) is high in any cycle.
- Reset (async): state=F0, ir=0, halted=0, illegal=0; CS_bus=0 for as long as RST_N is low.
- State sequence and control bits per state:
  - F0: pc_out, mar_in -> F1.
  - F1: mem_rd. When mem_rdy=1, also ir_in, pc_inc, and ir<=ibus on that edge -> DC. When mem_rdy=0, hold F1 and do not increment PC.
  - DC: CS_bus=0. Next state by opcode:
    - ALU-class or LDI -> OA.
    - HLT -> HALT.
    - NOP/illegal -> F0.
    - illegal=1 in this cycle only when the opcode is 8-E.
  - OA: pc_out, mar_in -> OR.
  - OR: mem_rd; hold while mem_rdy=0. When mem_rdy=1:
    - LDI: mdr_out, acc_in, pc_inc -> F0.
    - ALU-class: mdr_out, pc_inc, plus the opcode's ALU-select bit -> WB.
  - WB: z_out, plus acc_in for ADD/SUB/XOR/AND/OR or flag_in for CMP -> F0.
  - HALT: CS_bus=0, halted=1. Stays in HALT until reset.
- mem_rdy is combinational into CS_bus only in F1 and OR (strobes gated by ready).
- Latency with mem_rdy tied 1:
  - NOP/illegal: 3 cycles.
  - LDI: 5 cycles.
  - ALU-class: 6 cycles.
  - HLT: 3 cycles to halted=1.
- Each mem_rdy=0 cycle adds one cycle of latency.
- Reset mid-instruction aborts the instruction with no further strobes. The partially loaded ir is cleared.
- ibus is sampled only in F1 with mem_rdy=1.

Decomposition:
- Shared package cu_pkg:
  - CS bit-index localparams (ADD_B=0 ... Z_OUT_B=25), shared with the ALU.
  - Opcode constants.
  - State encoding (8 states, 3-bit).
- Natural sub-module cs_decode: combinational (state, ir[7:4], mem_rdy) -> CS_bus, illegal.
- The top level holds the state register, ir and halted.

Test Plan:
- Reset then mem_rdy=1, ibus=0x10 at F1, ibus=0x05 at OR -> cycle sequence F0,F1,DC,OA,OR,WB. CS_bus[0]=1 only in OR; CS_bus[25] and CS_bus[6] high in WB; back to F0 on cycle 7.
- CMP (0x30) -> CS_bus[1] in OR; WB asserts bits 25 and 14, bit 6 low.
- mem_rdy held 0 for 3 cycles in F1 -> mem_rd stays high, pc_inc/ir_in low for those cycles; ir loads on the first mem_rdy=1 edge.
- Opcode 0x9A -> illegal pulses exactly one cycle (DC), no ALU bits set, returns to F0 after 3 cycles.
- Opcode 0xF0 -> halted=1 from cycle 4 and stays; CS_bus=0; subsequent ibus/mem_rdy activity ignored.
- RST_N low during OR of an ADD -> CS_bus=0 immediately (before the next edge); after release the FSM resumes at F0 with ir=0.
